// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Anything that depends on NUM_DIGITS is sliced from the widest-case constant here.
package seg_pkg;

  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic {
    DEAD   = 1'b0,
    ACTIVE = 1'b1
  } scan_state_t;

  // Widest all-anodes-off pattern; users slice it down to their digit count.
  localparam logic [MAX_DIGITS-1:0] ANODES_OFF_ALL = '1;

  // Slot counter width: enough bits for the longer of the two phase lengths.
  function automatic int cnt_width(input int on_cycles, input int dead_cycles);
    int longest;
    longest = (on_cycles > dead_cycles) ? on_cycles : dead_cycles;
    return (longest < 2) ? 1 : $clog2(longest);
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero blank mask: digit i (i>0) is blanked when blank_lz is set and
// every nibble from i up to the most significant digit is zero.
module seg_lz_mask
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic                           blank_lz,
  output logic [NUM_DIGITS-1:0]          blank
);

  always_comb begin
    logic zero_above;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    blank      = '0;
    zero_above = 1'b1;
    // Walk downward from the MSD; digit 0 is never visited, so it is never blanked.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (value[NIBBLE_W*i +: NIBBLE_W] == '0);
      blank[i]   = blank_lz && zero_above;
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for a common-anode 7-segment bank: dead time, then one
// digit lit per slot, with the shown value swapped only at frame boundaries.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int ON_CYCLES   = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_in,
  input  logic                           load,
  input  logic                           blank_lz,
  input  logic [NUM_DIGITS-1:0]          digit_en,
  output logic [NIBBLE_W-1:0]            nibble_out,
  output logic [NUM_DIGITS-1:0]          anode_n,
  output logic                           frame_start
);

  localparam int CNT_W = cnt_width(ON_CYCLES, DEAD_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = NIBBLE_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      ON_LAST    = CNT_W'(ON_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = ANODES_OFF_ALL[NUM_DIGITS-1:0];

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [VAL_W-1:0] pending;
  logic [VAL_W-1:0] display;

  logic [IDX_W-1:0]      idx_next;
  logic                  dead_done;
  logic                  active_done;
  logic                  frame_wrap;
  logic [NUM_DIGITS-1:0] blank;
  logic [NUM_DIGITS-1:0] idx_sel;
  logic [NUM_DIGITS-1:0] anode_active;
  logic [VAL_W-1:0]      fetch_src;
  logic [NIBBLE_W-1:0]   fetch_nibble;

  // Nibble of digit i; a compare loop keeps non-power-of-two digit counts in range.
  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [VAL_W-1:0] v,
                                                    input logic [IDX_W-1:0] i);
    logic [NIBBLE_W-1:0] r;
    r = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (i == IDX_W'(d)) r = v[NIBBLE_W*d +: NIBBLE_W];
    end
    return r;
  endfunction

  seg_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .value   (display),
    .blank_lz(blank_lz),
    .blank   (blank)
  );

  always_comb begin
    dead_done   = (state == DEAD) && (cnt == DEAD_LAST);
    active_done = (state == ACTIVE) && (cnt == ON_LAST);
    idx_next    = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    frame_wrap  = active_done && (idx == IDX_LAST);

    for (int d = 0; d < NUM_DIGITS; d++) begin
      idx_sel[d] = (idx == IDX_W'(d));
    end
    anode_active = ~(idx_sel & digit_en & ~blank);

    // Digit 0 of a new frame must come from the value being copied in on this very edge.
    fetch_src    = frame_wrap ? pending : display;
    fetch_nibble = nibble_of(fetch_src, idx_next);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= DEAD;
      cnt         <= '0;
      idx         <= '0;
      nibble_out  <= '0;
      anode_n     <= ANODES_OFF;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      unique case (state)
        DEAD: begin
          if (dead_done) begin
            state       <= ACTIVE;
            cnt         <= '0;
            anode_n     <= anode_active;
            frame_start <= (idx == '0);
          end else begin
            cnt     <= cnt + CNT_W'(1);
            anode_n <= ANODES_OFF;
          end
        end
        ACTIVE: begin
          if (active_done) begin
            state      <= DEAD;
            cnt        <= '0;
            idx        <= idx_next;
            anode_n    <= ANODES_OFF;
            nibble_out <= fetch_nibble;
          end else begin
            cnt     <= cnt + CNT_W'(1);
            anode_n <= anode_active;
          end
        end
        default: begin
          state   <= DEAD;
          cnt     <= '0;
          anode_n <= ANODES_OFF;
        end
      endcase
    end
  end

  // Value path: loads land in pending; display only changes at the frame wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      display <= '0;
    end else begin
      if (load) pending <= value_in;
      if (frame_wrap) display <= pending;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with ON=4, DEAD=1: slot 5 cycles, frame 20.
// pos counts rising edges since reset release; outputs are sampled 1 time unit after each edge.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value_in = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_en = 4'b1111;
  logic [3:0]  nibble_out;
  logic [3:0]  anode_n;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;
  int pos      = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .ON_CYCLES  (4),
    .DEAD_CYCLES(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value_in   (value_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .digit_en   (digit_en),
    .nibble_out (nibble_out),
    .anode_n    (anode_n),
    .frame_start(frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic go_to(input int target);
    while (pos < target) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (anode_n !== 4'b1111 || nibble_out !== 4'h0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold anode_n=%b nibble=%h fs=%b exp anode_n=1111 nibble=0 fs=0",
               anode_n, nibble_out, frame_start);
    end
    rst = 1'b0;
    pos = 0;
  endtask

  // Frame 0 from reset: display 0, all digits lit in turn, frame_start on p=1.
  task automatic test_scan_basic();
    for (int p = 0; p < 20; p++) begin
      int d;
      logic [3:0] exp_an;
      go_to(p);
      d = p / 5;
      exp_an = 4'b1111;
      if (p % 5 != 0) exp_an[d] = 1'b0;
      checks++;
      if (anode_n !== exp_an || nibble_out !== 4'h0 || frame_start !== (p == 1)) begin
        failures++;
        $display("FAIL scan_basic p=%0d anode_n=%b nibble=%h fs=%b exp %b 0 %b",
                 p, anode_n, nibble_out, frame_start, exp_an, (p == 1));
      end
    end
  endtask

  // Mid-frame load of 12AF is invisible until the wrap, then shows F,A,2,1.
  task automatic test_load_midframe();
    logic [15:0] v;
    go_to(22);
    value_in = 16'h12AF;
    load = 1'b1;
    tick();
    load = 1'b0;
    v = 16'h12AF;
    for (int p = 23; p < 60; p++) begin
      int d;
      logic [3:0] exp_an;
      logic [3:0] exp_nib;
      go_to(p);
      d = (p % 20) / 5;
      exp_an = 4'b1111;
      if (p % 5 != 0) exp_an[d] = 1'b0;
      exp_nib = (p < 40) ? 4'h0 : v[4*d +: 4];
      checks++;
      if (anode_n !== exp_an || nibble_out !== exp_nib || frame_start !== (p % 20 == 1)) begin
        failures++;
        $display("FAIL load_midframe p=%0d anode_n=%b nibble=%h fs=%b exp %b %h %b",
                 p, anode_n, nibble_out, frame_start, exp_an, exp_nib, (p % 20 == 1));
      end
    end
  endtask

  // 0050 with blanking: digits 3,2 dark; then 0000: only digit 0 lit.
  task automatic test_lz_blank();
    logic [15:0] v;
    logic [3:0]  lit;
    go_to(61);
    blank_lz = 1'b1;
    value_in = 16'h0050;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int p = 80; p < 120; p++) begin
      int d;
      logic [3:0] exp_an;
      logic [3:0] exp_nib;
      go_to(p);
      load = 1'b0;
      v   = (p < 100) ? 16'h0050 : 16'h0000;
      lit = (p < 100) ? 4'b0011 : 4'b0001;
      d = (p % 20) / 5;
      exp_an = 4'b1111;
      if (p % 5 != 0 && lit[d]) exp_an[d] = 1'b0;
      exp_nib = v[4*d +: 4];
      checks++;
      if (anode_n !== exp_an || nibble_out !== exp_nib) begin
        failures++;
        $display("FAIL lz_blank p=%0d anode_n=%b nibble=%h exp %b %h",
                 p, anode_n, nibble_out, exp_an, exp_nib);
      end
      if (p == 90) begin
        value_in = 16'h0000;
        load = 1'b1;
      end
    end
  endtask

  // digit_en=1011: digit 2 stays dark, frame still 20 cycles.
  task automatic test_digit_en();
    go_to(119);
    blank_lz = 1'b0;
    digit_en = 4'b1011;
    for (int p = 120; p < 142; p++) begin
      int d;
      logic [3:0] exp_an;
      go_to(p);
      d = (p % 20) / 5;
      exp_an = 4'b1111;
      if (p % 5 != 0 && d != 2) exp_an[d] = 1'b0;
      checks++;
      if (anode_n !== exp_an || nibble_out !== 4'h0 || frame_start !== (p % 20 == 1)) begin
        failures++;
        $display("FAIL digit_en p=%0d anode_n=%b nibble=%h fs=%b exp %b 0 %b",
                 p, anode_n, nibble_out, frame_start, exp_an, (p % 20 == 1));
      end
    end
    digit_en = 4'b1111;
  endtask

  // Load on the wrap edge itself lands one frame later than the pending value.
  task automatic test_back_to_back();
    logic [15:0] v;
    go_to(145);
    value_in = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    go_to(159);
    value_in = 16'hBEEF;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int p = 160; p < 200; p++) begin
      int d;
      logic [3:0] exp_an;
      logic [3:0] exp_nib;
      go_to(p);
      v = (p < 180) ? 16'h1234 : 16'hBEEF;
      d = (p % 20) / 5;
      exp_an = 4'b1111;
      if (p % 5 != 0) exp_an[d] = 1'b0;
      exp_nib = v[4*d +: 4];
      checks++;
      if (anode_n !== exp_an || nibble_out !== exp_nib) begin
        failures++;
        $display("FAIL back_to_back p=%0d anode_n=%b nibble=%h exp %b %h",
                 p, anode_n, nibble_out, exp_an, exp_nib);
      end
    end
  endtask

  // Async reset mid-ACTIVE of digit 2; scan and value restart from zero.
  task automatic test_reset_mid_active();
    go_to(212);
    checks++;
    if (anode_n !== 4'b1011 || nibble_out !== 4'hE) begin
      failures++;
      $display("FAIL pre_reset anode_n=%b nibble=%h exp 1011 e", anode_n, nibble_out);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (anode_n !== 4'b1111 || nibble_out !== 4'h0 || frame_start !== 1'b0) begin
      failures++;
      $display("FAIL async_reset anode_n=%b nibble=%h fs=%b exp 1111 0 0",
               anode_n, nibble_out, frame_start);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    pos = 0;
    for (int p = 0; p < 40; p++) begin
      int d;
      logic [3:0] exp_an;
      go_to(p);
      d = (p % 20) / 5;
      exp_an = 4'b1111;
      if (p % 5 != 0) exp_an[d] = 1'b0;
      checks++;
      if (anode_n !== exp_an || nibble_out !== 4'h0 || frame_start !== (p % 20 == 1)) begin
        failures++;
        $display("FAIL restart p=%0d anode_n=%b nibble=%h fs=%b exp %b 0 %b",
                 p, anode_n, nibble_out, frame_start, exp_an, (p % 20 == 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_basic();
    test_load_midframe();
    test_lz_blank();
    test_digit_en();
    test_back_to_back();
    test_reset_mid_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog pos=%0d limit reached", pos);
    $fatal(1, "watchdog");
  end

endmodule
